rsa_stream_adapter: RTL and testbench

Byte-stream front end for the 256-bit square-and-multiply modular exponentiator. It loads the key bytes (e, then n) and message bytes (m) from a valid/ready byte stream and checks m < n. It then launches one exponentiation and returns the 256-bit result as a big-endian byte stream. It sits between the link/UART byte layer and the exponentiator, and owns the exponentiator's `ready`/`valid` handshake.

---
 rtl/rsa_stream_adapter.sv | 162 ++++++++++++++++
 tb/tb_rsa_stream_adapter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_adapter.sv
// rsa_stream_adapter: byte-stream front end for the 256-bit modular exponentiator.
// It collects the key (e then n) and the message m as big-endian byte streams,
// checks that m < n, launches one exponentiation, and streams the result back out.
//
// Handshake rule for both byte ports: a byte moves on a rising clk edge where
// valid && ready. A producer holds data stable while valid is high and ready is
// low. ready never depends on valid on the same port.
module rsa_stream_adapter #(
  parameter  int NBYTES = 32,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic         key_ok,
  output logic         busy,
  output logic [W-1:0] me_m,
  output logic [W-1:0] me_e,
  output logic [W-1:0] me_n,
  output logic         me_start,
  input  logic         me_valid,
  input  logic [W-1:0] me_out,
  output logic [2:0]   dbg_state
);

  localparam int CW = $clog2(2 * NBYTES);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_CHECK   = 3'd1,
    S_START   = 3'd2,
    S_ARM     = 3'd3,
    S_WAIT    = 3'd4,
    S_SEND    = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_e;
  logic [W-1:0]   r_n;
  logic [W-1:0]   r_m;
  logic [W-1:0]   r_out;
  logic [CW-1:0]  r_key_cnt;
  logic [CW-1:0]  r_msg_cnt;
  logic [CW-1:0]  r_out_cnt;
  logic           r_key_ok;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_reject;
  logic           w_err;
  logic           w_start;
  logic           w_last_msg;
  logic           w_last_out;

  // Only COLLECT accepts input; held low while reset is asserted.
  assign in_ready   = (r_state == S_COLLECT) && !reset;
  assign out_valid  = (r_state == S_SEND);
  assign out_data   = r_out[W-1 -: 8];
  assign busy       = (r_state != S_COLLECT);
  assign key_ok     = r_key_ok;
  assign err        = w_err;
  assign me_start   = w_start;
  assign me_m       = r_m;
  assign me_e       = r_e;
  assign me_n       = r_n;
  assign dbg_state  = r_state;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_last_msg = (r_msg_cnt == CW'(NBYTES - 1));
  assign w_last_out = (r_out_cnt == CW'(NBYTES - 1));
  // A zero modulus is rejected explicitly even though m >= 0 already covers it.
  assign w_reject   = !r_key_ok || (r_m >= r_n) || (r_n == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_COLLECT;
    else       r_state <= w_state_nxt;
  end

  // Next-state and one-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_COLLECT: if (w_in_fire && !in_key && w_last_msg) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_reject) begin
          w_err       = 1'b1;
          w_state_nxt = S_COLLECT;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_ARM;
      end
      // The previous run leaves me_valid high until the exponentiator re-inits.
      S_ARM:   if (!me_valid) w_state_nxt = S_WAIT;
      S_WAIT:  if (me_valid) w_state_nxt = S_SEND;
      S_SEND:  if (w_out_fire && w_last_out) w_state_nxt = S_COLLECT;
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // Key and message shift registers with their byte counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e       <= '0;
      r_n       <= '0;
      r_m       <= '0;
      r_key_cnt <= '0;
      r_msg_cnt <= '0;
      r_key_ok  <= 1'b0;
    end else if (w_in_fire) begin
      if (in_key) begin
        // Any key byte discards a partially collected message.
        r_msg_cnt <= '0;
        if (r_key_cnt < CW'(NBYTES)) r_e <= W'({r_e, in_data});
        else                         r_n <= W'({r_n, in_data});
        if (r_key_cnt == CW'(2 * NBYTES - 1)) begin
          r_key_cnt <= '0;
          r_key_ok  <= 1'b1;
        end else begin
          r_key_cnt <= r_key_cnt + CW'(1);
          r_key_ok  <= 1'b0;
        end
      end else begin
        // A message byte aborts a partial key load; key_ok is already low then.
        r_key_cnt <= '0;
        r_m       <= W'({r_m, in_data});
        if (w_last_msg) r_msg_cnt <= '0;
        else            r_msg_cnt <= r_msg_cnt + CW'(1);
      end
    end
  end

  // Result shift register: loaded from the exponentiator, drained MSB byte first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out     <= '0;
      r_out_cnt <= '0;
    end else if (r_state == S_WAIT && me_valid) begin
      r_out     <= me_out;
      r_out_cnt <= '0;
    end else if (w_out_fire) begin
      r_out <= r_out << 8;
      if (w_last_out) r_out_cnt <= '0;
      else            r_out_cnt <= r_out_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rsa_stream_adapter.sv
// Testbench for rsa_stream_adapter: behavioural exponentiator, byte drivers,
// output monitor and scenario tasks.
module tb_rsa_stream_adapter;

  localparam int NBYTES = 32;
  localparam int W      = 8 * NBYTES;
  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   in_data   = 8'h00;
  logic         in_key    = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         err;
  logic         key_ok;
  logic         busy;
  logic [W-1:0] me_m, me_e, me_n;
  logic         me_start;
  logic         me_valid  = 1'b0;
  logic [W-1:0] me_out    = '0;
  logic [2:0]   dbg_state;

  rsa_stream_adapter #(.NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_key(in_key), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .key_ok(key_ok), .busy(busy),
    .me_m(me_m), .me_e(me_e), .me_n(me_n), .me_start(me_start),
    .me_valid(me_valid), .me_out(me_out), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] r, x, nn;
    nn = {{W{1'b0}}, n};
    r  = 1 % nn;
    x  = {{W{1'b0}}, b} % nn;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * x) % nn;
    end
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- behavioural exponentiator ----------------
  int           exp_lat = 3;
  int           exp_cnt = 0;
  logic [W-1:0] exp_res = '0;
  always @(negedge clk) begin
    if (reset) begin
      me_valid <= 1'b0;
      me_out   <= '0;
      exp_cnt  <= 0;
    end else if (me_start) begin
      exp_res <= modexp(me_m, me_e, me_n);
      exp_cnt <= exp_lat + int'($urandom_range(0, 3));
    end else if (exp_cnt > 1) begin
      me_valid <= 1'b0;
      exp_cnt  <= exp_cnt - 1;
    end else if (exp_cnt == 1) begin
      me_valid <= 1'b1;
      me_out   <= exp_res;
      exp_cnt  <= 0;
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_q[$];
  int rd_idx      = 0;
  int n_start     = 0;
  int n_err       = 0;
  int n_bad_ready = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (me_start) n_start <= n_start + 1;
      if (err) n_err <= n_err + 1;
      if (busy && in_ready) n_bad_ready <= n_bad_ready + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic k);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_key   = k;
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic k, input int nb);
    for (int i = 0; i < nb; i++) send_byte(v[W-1-8*i -: 8], k);
  endtask

  task automatic load_key(input logic [W-1:0] e, input logic [W-1:0] n);
    send_word(e, 1'b1, NBYTES);
    send_word(n, 1'b1, NBYTES);
  endtask

  task automatic wait_result(output logic [W-1:0] v);
    int t = 0;
    v = '0;
    while (got_q.size() < rd_idx + NBYTES && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (got_q.size() < rd_idx + NBYTES) begin
      n_fail++;
      $display("FAIL result_timeout bytes=%0d required %0d", got_q.size() - rd_idx, NBYTES);
      rd_idx = got_q.size();
    end else begin
      for (int i = 0; i < NBYTES; i++) v = {v[W-9:0], got_q[rd_idx + i]};
      rd_idx += NBYTES;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_held got=%0b required 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b required 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b required 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%0h required 0", out_data); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b required 0", err); end
    n_checks++; if (key_ok !== 1'b0) begin n_fail++; $display("FAIL reset_key_ok got=%0b required 0", key_ok); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b required 0", busy); end
    n_checks++; if (me_start !== 1'b0) begin n_fail++; $display("FAIL reset_me_start got=%0b required 0", me_start); end
    n_checks++; if ((me_m | me_e | me_n) !== '0) begin n_fail++; $display("FAIL reset_operands got nonzero required 0"); end
    n_checks++; if (dbg_state !== ST_COLLECT) begin n_fail++; $display("FAIL reset_state got=%0d required %0d", dbg_state, ST_COLLECT); end
  endtask

  task automatic test_basic();
    logic [W-1:0] v, e;
    int s0;
    load_key(W'(2), W'(32'h10001));
    n_checks++; if (key_ok !== 1'b1) begin n_fail++; $display("FAIL basic_key_ok got=%0b required 1", key_ok); end
    s0 = n_start;
    exp_q.push_back(W'(1));
    send_msg_checked(W'(32'h10000), W'(2), W'(32'h10001));
    wait_result(v);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) begin n_fail++; $display("FAIL basic_result got=%0h required %0h", v, e); end
    repeat (2) @(negedge clk);
    n_checks++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL basic_start_count got=%0d required 1", n_start - s0); end
    n_checks++; if (key_ok !== 1'b1) begin n_fail++; $display("FAIL basic_key_kept got=%0b required 1", key_ok); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_after got=%0b required 1", in_ready); end
  endtask

  // Sends a message and checks the launch timing and the operands presented.
  task automatic send_msg_checked(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
    send_word(m, 1'b0, NBYTES);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || me_start !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL check_cycle busy=%0b me_start=%0b in_ready=%0b required 1 0 0", busy, me_start, in_ready);
    end
    @(negedge clk);
    n_checks++; if (me_start !== 1'b1) begin n_fail++; $display("FAIL start_cycle me_start=%0b required 1", me_start); end
    n_checks++; if (me_m !== m || me_e !== e || me_n !== n) begin
      n_fail++; $display("FAIL operands m=%0h e=%0h n=%0h required %0h %0h %0h", me_m, me_e, me_n, m, e, n);
    end
  endtask

  task automatic test_key_reload();
    logic [W-1:0] v, e;
    load_key(W'(3), W'(32'h10001));
    exp_q.push_back(W'(8));
    send_msg_checked(W'(2), W'(3), W'(32'h10001));
    wait_result(v);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) begin n_fail++; $display("FAIL reload_result got=%0h required %0h", v, e); end
    exp_q.push_back(W'(32'h1b));
    send_msg_checked(W'(3), W'(3), W'(32'h10001));
    wait_result(v);
    e = exp_q.pop_front();
    n_checks++; if (v !== e) begin n_fail++; $display("FAIL repeat_result got=%0h required %0h", v, e); end
  endtask

  task automatic test_reject();
    logic [W-1:0] n;
    int s0, e0;
    do_reset();
    repeat (2) @(negedge clk);
    s0 = n_start;
    e0 = n_err;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) load_key(W'(2), W'(32'h10001));
      if (c == 2) load_key(W'(7), '0);
      if (c == 3) begin
        n = rand256() >> 8;
        load_key(rand256(), n);
      end
      case (c)
        0: send_word(W'(5), 1'b0, NBYTES);
        1: send_word(W'(32'h10001), 1'b0, NBYTES);
        2: send_word('0, 1'b0, NBYTES);
        default: send_word(n + W'($urandom_range(0, 1000)), 1'b0, NBYTES);
      endcase
      @(negedge clk);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL reject_err_pulse case=%0d got=%0b required 1", c, err); end
      @(negedge clk);
      n_checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL reject_return case=%0d err=%0b in_ready=%0b required 0 1", c, err, in_ready);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++; if (n_err - e0 !== 4) begin n_fail++; $display("FAIL reject_err_count got=%0d required 4", n_err - e0); end
    n_checks++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL reject_no_start got=%0d required 0", n_start - s0); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e, n, m, v, x;
    logic prev_v, prev_r;
    logic [7:0] prev_d;
    int t, b0;
    e = rand256();
    n = rand256() | {1'b1, {(W-1){1'b0}}};
    m = rand256() % n;
    load_key(e, n);
    exp_q.push_back(modexp(m, e, n));
    b0 = n_bad_ready;
    send_word(m, 1'b0, NBYTES);
    prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'h00; t = 0;
    while (got_q.size() < rd_idx + NBYTES && t < 3000) begin
      @(posedge clk); #1;
      out_ready = (t % 4 == 0) || (t % 4 == 3);
      @(negedge clk);
      t++;
      if (prev_v && !prev_r) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== prev_d) begin
          n_fail++; $display("FAIL stall_hold valid=%0b data=%0h required 1 %0h", out_valid, out_data, prev_d);
        end
      end
      if (out_valid) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL in_ready_while_send got=%0b required 0", in_ready); end
      end
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_result(v);
    x = exp_q.pop_front();
    n_checks++; if (v !== x) begin n_fail++; $display("FAIL backpressure_result got=%0h required %0h", v, x); end
    n_checks++; if (n_bad_ready - b0 !== 0) begin n_fail++; $display("FAIL busy_in_ready cycles=%0d required 0", n_bad_ready - b0); end
  endtask

  task automatic test_interleave();
    logic [W-1:0] e2, n2, m, v, x;
    int s0, e0;
    load_key(W'(3), W'(32'h10001));
    send_word(rand256(), 1'b0, 10);
    e2 = rand256();
    n2 = rand256() | {1'b1, {(W-1){1'b0}}};
    load_key(e2, n2);
    n_checks++; if (key_ok !== 1'b1) begin n_fail++; $display("FAIL interleave_key_ok got=%0b required 1", key_ok); end
    m = rand256() % n2;
    exp_q.push_back(modexp(m, e2, n2));
    send_word(m, 1'b0, NBYTES);
    wait_result(v);
    x = exp_q.pop_front();
    n_checks++; if (v !== x) begin n_fail++; $display("FAIL interleave_result got=%0h required %0h", v, x); end
    repeat (2) @(negedge clk);
    s0 = n_start;
    e0 = n_err;
    send_byte(8'h5a, 1'b1);
    n_checks++; if (key_ok !== 1'b0) begin n_fail++; $display("FAIL first_key_byte_clears got=%0b required 0", key_ok); end
    send_word(rand256(), 1'b1, 19);
    m = W'(1);
    send_byte(8'h00, 1'b0);
    n_checks++; if (key_ok !== 1'b0) begin n_fail++; $display("FAIL aborted_key_ok got=%0b required 0", key_ok); end
    send_word(m << 8, 1'b0, NBYTES - 1);
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL aborted_key_err got=%0b required 1", err); end
    repeat (2) @(negedge clk);
    n_checks++; if (n_start - s0 !== 0 || n_err - e0 !== 1) begin
      n_fail++; $display("FAIL aborted_counts start=%0d err=%0d required 0 1", n_start - s0, n_err - e0);
    end
  endtask

  task automatic test_reset_wait();
    logic [W-1:0] m;
    int t, g0, s0;
    load_key(W'(2), W'(32'h10001));
    exp_lat = 60;
    m = W'(32'h10000);
    send_word(m, 1'b0, NBYTES);
    t = 0;
    while (dbg_state !== ST_WAIT && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL reach_wait state=%0d required %0d", dbg_state, ST_WAIT); end
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_out valid=%0b data=%0h err=%0b required 0 0 0", out_valid, out_data, err);
    end
    n_checks++; if (key_ok !== 1'b0 || busy !== 1'b0 || me_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_flags key_ok=%0b busy=%0b me_start=%0b required 0 0 0", key_ok, busy, me_start);
    end
    n_checks++; if ((me_m | me_e | me_n) !== '0 || in_ready !== 1'b1 || dbg_state !== ST_COLLECT) begin
      n_fail++; $display("FAIL rst_wait_state in_ready=%0b state=%0d required 1 %0d", in_ready, dbg_state, ST_COLLECT);
    end
    g0 = got_q.size();
    s0 = n_start;
    repeat (100) @(negedge clk);
    n_checks++; if (got_q.size() !== g0 || n_start !== s0) begin
      n_fail++; $display("FAIL rst_wait_quiet bytes=%0d starts=%0d required 0 0", got_q.size() - g0, n_start - s0);
    end
    exp_lat = 3;
  endtask

  task automatic test_random();
    logic [W-1:0] e, n, m, v, x;
    e = rand256();
    n = rand256() | {1'b1, {(W-1){1'b0}}};
    load_key(e, n);
    for (int k = 0; k < 3; k++) begin
      m = rand256() % n;
      exp_lat = int'($urandom_range(2, 12));
      exp_q.push_back(modexp(m, e, n));
      send_word(m, 1'b0, NBYTES);
      wait_result(v);
      x = exp_q.pop_front();
      n_checks++; if (v !== x) begin n_fail++; $display("FAIL random_result k=%0d got=%0h required %0h", k, v, x); end
    end
    exp_lat = 3;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_key_reload();
    test_reject();
    test_backpressure();
    test_interleave();
    test_reset_wait();
    test_random();
    repeat (5) @(negedge clk);
    n_checks++; if (got_q.size() !== rd_idx) begin n_fail++; $display("FAIL extra_output_bytes got=%0d required 0", got_q.size() - rd_idx); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL pending_expected got=%0d required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
